// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core: memory map anchors and the
// fetch-stage handler-mode state encoding.
package mips_pkg;

   localparam int unsigned      ADDR_W          = 32;
   localparam logic [31:0]      PC_RESET_VEC    = 32'h0000_3000;
   localparam logic [31:0]      TEXT_LO         = 32'h0000_3000;
   localparam logic [31:0]      TEXT_HI         = 32'h0000_6ffc;
   localparam logic [31:0]      EXC_HANDLER_VEC = 32'h0000_4180;

   typedef enum logic {
      RUN     = 1'b0,
      HANDLER = 1'b1
   } pc_state_e;

endpackage

// File: rtl/pc_addr_check.sv
// Combinational address-error check: flags a misaligned address or one
// outside [TEXT_LO, TEXT_HI]. Shared by fetch AdEL and data AdEL/AdES.
module pc_addr_check #(
   parameter int unsigned          WIDTH      = 32,
   parameter logic [WIDTH-1:0]     TEXT_LO    = '0,
   parameter logic [WIDTH-1:0]     TEXT_HI    = '1,
   parameter int unsigned          ALIGN_BITS = 2
) (
   input  logic [WIDTH-1:0] addr,
   output logic             fault
);

   // Mask form keeps ALIGN_BITS = 0 (byte access) legal without a zero-width slice.
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

   logic misaligned;
   logic below;
   logic above;

   always_comb begin
      misaligned = (addr & ALIGN_MASK) != '0;
      below      = addr < TEXT_LO;
      above      = addr > TEXT_HI;
      fault      = misaligned || below || above;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with exception entry, ERET return and registered
// AdEL flag; a two-state handler-mode FSM masks nested exception requests.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RUN     | normal fetch; exc_req redirects to the handler vector
//   HANDLER | inside the exception handler; exc_req ignored until eret
module pc_gen
   import mips_pkg::*;
#(
   parameter int unsigned      WIDTH       = ADDR_W,
   parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(PC_RESET_VEC),
   parameter logic [WIDTH-1:0] TEXT_LO     = WIDTH'(mips_pkg::TEXT_LO),
   parameter logic [WIDTH-1:0] TEXT_HI     = WIDTH'(mips_pkg::TEXT_HI),
   parameter logic [WIDTH-1:0] HANDLER_VEC = WIDTH'(EXC_HANDLER_VEC),
   parameter int unsigned      ALIGN_BITS  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [WIDTH-1:0] npc,
   input  logic             exc_req,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic             adel,
   output logic             in_handler
);

   pc_state_e        state;
   pc_state_e        state_next;
   logic [WIDTH-1:0] pc_next;
   logic             adel_next;
   logic             take_exc;
   logic [WIDTH-1:0] chk_addr;
   logic             chk_fault;

   // Only one candidate address can be committed per cycle, so one checker suffices.
   assign chk_addr = eret ? epc : npc;

   pc_addr_check #(
      .WIDTH      (WIDTH),
      .TEXT_LO    (TEXT_LO),
      .TEXT_HI    (TEXT_HI),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_chk (
      .addr  (chk_addr),
      .fault (chk_fault)
   );

   assign take_exc = exc_req && (state == RUN);

   always_comb begin
      state_next = state;
      pc_next    = pc;
      adel_next  = adel;
      if (take_exc) begin
         state_next = HANDLER;
         pc_next    = HANDLER_VEC;
         adel_next  = 1'b0;
      end else if (eret) begin
         state_next = RUN;
         pc_next    = epc;
         adel_next  = chk_fault;
      end else if (!stall) begin
         pc_next    = npc;
         adel_next  = chk_fault;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         pc    <= RESET_VEC;
         adel  <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         adel  <= adel_next;
      end
   end

   assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a directed vector table followed by a
// randomised run against an independent behavioural model.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic [31:0] npc = '0;
   logic        exc_req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] pc;
   logic        adel;
   logic        in_handler;

   pc_gen dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .npc        (npc),
      .exc_req    (exc_req),
      .eret       (eret),
      .epc        (epc),
      .pc         (pc),
      .adel       (adel),
      .in_handler (in_handler)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        exc;
      logic        ert;
      logic [31:0] n;
      logic [31:0] e;
      logic [31:0] exp_pc;
      logic        exp_adel;
      logic        exp_inh;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] exp_pc;
      logic        exp_adel;
      logic        exp_inh;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mk(logic rst, logic stl, logic exc, logic ert,
                               logic [31:0] n, logic [31:0] e,
                               logic [31:0] xp, logic xa, logic xi);
      vec_t v;
      v.rst = rst; v.stl = stl; v.exc = exc; v.ert = ert; v.n = n; v.e = e;
      v.exp_pc = xp; v.exp_adel = xa; v.exp_inh = xi;
      return v;
   endfunction

   function automatic logic chk(logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6ffc);
   endfunction

   task automatic drive(logic rst, logic stl, logic exc, logic ert,
                        logic [31:0] n, logic [31:0] e);
      @(negedge clk);
      reset = rst; stall = stl; exc_req = exc; eret = ert; npc = n; epc = e;
   endtask

   task automatic check_one(int id);
      exp_t x;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         tests++; fails++;
         $display("FAIL sb_empty id=%0d", id);
         return;
      end
      x = sb.pop_front();
      tests++;
      if (pc !== x.exp_pc) begin
         fails++;
         $display("FAIL pc id=%0d got=%h exp=%h", x.id, pc, x.exp_pc);
      end
      tests++;
      if (adel !== x.exp_adel) begin
         fails++;
         $display("FAIL adel id=%0d got=%b exp=%b", x.id, adel, x.exp_adel);
      end
      tests++;
      if (in_handler !== x.exp_inh) begin
         fails++;
         $display("FAIL in_handler id=%0d got=%b exp=%b", x.id, in_handler, x.exp_inh);
      end
   endtask

   // independent reference state for the random phase
   logic        m_hdl;
   logic [31:0] m_pc;
   logic        m_adel;

   initial begin
      // reset and sequential fetch, including bounds
      tbl.push_back(mk(1,0,0,0, 32'h0,    32'h0,    32'h3000, 0, 0));
      tbl.push_back(mk(0,0,0,0, 32'h3004, 32'h0,    32'h3004, 0, 0));
      tbl.push_back(mk(0,0,0,0, 32'h3006, 32'h0,    32'h3006, 1, 0));
      tbl.push_back(mk(0,0,0,0, 32'h2ffc, 32'h0,    32'h2ffc, 1, 0));
      tbl.push_back(mk(0,0,0,0, 32'h7000, 32'h0,    32'h7000, 1, 0));
      tbl.push_back(mk(0,0,0,0, 32'h6ffc, 32'h0,    32'h6ffc, 0, 0));
      tbl.push_back(mk(0,0,0,0, 32'h3000, 32'h0,    32'h3000, 0, 0));
      tbl.push_back(mk(0,0,0,0, 32'h0,    32'h0,    32'h0,    1, 0));
      tbl.push_back(mk(0,0,0,0, 32'hfffffffc, 32'h0, 32'hfffffffc, 1, 0));
      // stall holds a faulting pc with its flag
      tbl.push_back(mk(0,0,0,0, 32'h3001, 32'h0,    32'h3001, 1, 0));
      tbl.push_back(mk(0,1,0,0, 32'h3010, 32'h0,    32'h3001, 1, 0));
      tbl.push_back(mk(0,0,0,0, 32'h3008, 32'h0,    32'h3008, 0, 0));
      tbl.push_back(mk(0,1,0,0, 32'h3010, 32'h0,    32'h3008, 0, 0));
      tbl.push_back(mk(0,1,0,0, 32'h3010, 32'h0,    32'h3008, 0, 0));
      tbl.push_back(mk(0,1,0,0, 32'h3010, 32'h0,    32'h3008, 0, 0));
      // exception entry overrides stall; nested exc ignored
      tbl.push_back(mk(0,1,1,0, 32'h3010, 32'h0,    32'h4180, 0, 1));
      tbl.push_back(mk(0,0,1,0, 32'h4184, 32'h0,    32'h4184, 0, 1));
      tbl.push_back(mk(0,1,0,0, 32'h4188, 32'h0,    32'h4184, 0, 1));
      tbl.push_back(mk(0,0,0,1, 32'h4188, 32'h3020, 32'h3020, 0, 0));
      // eret from RUN, then exc+eret from RUN: exception wins
      tbl.push_back(mk(0,0,0,1, 32'h3024, 32'h3022, 32'h3022, 1, 0));
      tbl.push_back(mk(0,0,1,1, 32'h3024, 32'h3040, 32'h4180, 0, 1));
      // exc+eret from HANDLER: eret wins; eret overrides stall
      tbl.push_back(mk(0,1,1,1, 32'h4184, 32'h6ffc, 32'h6ffc, 0, 0));
      tbl.push_back(mk(0,0,1,0, 32'h3000, 32'h0,    32'h4180, 0, 1));
      tbl.push_back(mk(0,1,0,1, 32'h3000, 32'h7000, 32'h7000, 1, 0));
      // reset mid-handler beats everything
      tbl.push_back(mk(0,0,1,0, 32'h3000, 32'h0,    32'h4180, 0, 1));
      tbl.push_back(mk(1,1,1,1, 32'h3000, 32'h3021, 32'h3000, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         exp_t x;
         drive(tbl[i].rst, tbl[i].stl, tbl[i].exc, tbl[i].ert, tbl[i].n, tbl[i].e);
         x.id = i; x.exp_pc = tbl[i].exp_pc; x.exp_adel = tbl[i].exp_adel;
         x.exp_inh = tbl[i].exp_inh;
         sb.push_back(x);
         check_one(i);
      end

      // random phase; model starts from the reset applied by the last vector
      m_hdl = 1'b0; m_pc = 32'h3000; m_adel = 1'b0;
      for (int k = 0; k < 400; k++) begin
         logic        r, s, x_e, x_r;
         logic [31:0] n, e;
         exp_t        x;
         r   = ($urandom_range(99) < 2);
         s   = ($urandom_range(99) < 25);
         x_e = ($urandom_range(99) < 12);
         x_r = ($urandom_range(99) < 12);
         case ($urandom_range(5))
            0:       n = 32'h6ffc + 32'(4 * $urandom_range(1));
            1:       n = 32'h2ffc + 32'(4 * $urandom_range(1));
            2:       n = 32'h3000 + 32'($urandom_range(32'h3fff));
            default: n = 32'h3000 + 32'(4 * $urandom_range(32'hfff));
         endcase
         e = $urandom_range(1) ? (32'h3000 + 32'(4 * $urandom_range(32'hfff)))
                               : $urandom();
         drive(r, s, x_e, x_r, n, e);
         if (r) begin
            m_hdl = 1'b0; m_pc = 32'h3000; m_adel = 1'b0;
         end else if (x_e && !m_hdl) begin
            m_hdl = 1'b1; m_pc = 32'h4180; m_adel = 1'b0;
         end else if (x_r) begin
            m_hdl = 1'b0; m_pc = e; m_adel = chk(e);
         end else if (!s) begin
            m_pc = n; m_adel = chk(n);
         end
         x.id = 1000 + k; x.exp_pc = m_pc; x.exp_adel = m_adel; x.exp_inh = m_hdl;
         sb.push_back(x);
         check_one(1000 + k);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
